uart_tx: RTL

Serial transmitter stage directly downstream of the baud-rate generator: consumes its one-cycle `baud_tick` strobe and serialises parallel bytes onto the UART TX line. Frame format is start bit, DATA_BITS data bits LSB-first, optional parity, then STOP_BITS stop bits. Parent UART top instances the baud generator and this block side by side and shares `clk`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-format bounds.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd5
   } uart_tx_state_t;

   localparam int   DATA_BITS_MIN = 5;
   localparam int   DATA_BITS_MAX = 9;
   localparam int   STOP_BITS_MIN = 1;
   localparam int   STOP_BITS_MAX = 2;
   localparam logic IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits,
// paced by the baud generator's tick. Parity bit is compiled in with UART_TX_PARITY_EN.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx
);

   localparam int               CNT_W     = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   generate
      if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX) ||
          (STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX) ||
          (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
         $error("uart_tx: illegal DATA_BITS/STOP_BITS/PARITY_ODD configuration");
      end
   endgenerate

   uart_tx_state_t       state_r;
   uart_tx_state_t       state_nxt_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_nxt_s;
   logic [CNT_W-1:0]     bit_cnt_r;
   logic [CNT_W-1:0]     bit_cnt_nxt_s;
   logic                 stop_cnt_r;
   logic                 stop_cnt_nxt_s;
   logic                 tx_r;
   logic                 tx_nxt_s;
   logic                 done_r;
   logic                 done_nxt_s;
   logic                 ready_r;
   logic                 busy_r;

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_INV = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   // The shift register is consumed during DATA, so parity comes from a separate latched copy.
   logic [DATA_BITS-1:0] data_r;
   logic [DATA_BITS-1:0] data_nxt_s;
   logic                 parity_s;

   assign parity_s = (^data_r) ^ PAR_INV;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; ticks are ignored in IDLE so a tick on the acceptance edge is never used.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (tx_valid) begin
               state_nxt_s = ST_SYNC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (baud_tick) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_SYNC;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (baud_tick && (bit_cnt_r == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               state_nxt_s = ST_PARITY;
`else
               state_nxt_s = ST_STOP;
`endif
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (baud_tick && (stop_cnt_r == STOP_LAST)) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath and output next values; the line level for each bit is chosen one edge ahead.
   always_comb begin
      shift_nxt_s    = shift_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      stop_cnt_nxt_s = stop_cnt_r;
      tx_nxt_s       = tx_r;
      done_nxt_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
      data_nxt_s     = data_r;
`endif
      case (state_r)
         ST_IDLE: begin
            tx_nxt_s = IDLE_LEVEL;
            if (tx_valid) begin
               shift_nxt_s = tx_data;
`ifdef UART_TX_PARITY_EN
               data_nxt_s  = tx_data;
`endif
            end else begin
               shift_nxt_s = shift_r;
            end
         end
         ST_SYNC: begin
            if (baud_tick) begin
               tx_nxt_s = ~IDLE_LEVEL;
            end else begin
               tx_nxt_s = tx_r;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               tx_nxt_s      = shift_r[0];
               bit_cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
               tx_nxt_s = tx_r;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_nxt_s = parity_s;
`else
                  tx_nxt_s = IDLE_LEVEL;
`endif
                  stop_cnt_nxt_s = 1'b0;
               end else begin
                  shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                  bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                  tx_nxt_s      = shift_r[1];
               end
            end else begin
               tx_nxt_s = tx_r;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               tx_nxt_s       = IDLE_LEVEL;
               stop_cnt_nxt_s = 1'b0;
            end else begin
               tx_nxt_s = tx_r;
            end
         end
`endif
         ST_STOP: begin
            tx_nxt_s = IDLE_LEVEL;
            if (baud_tick) begin
               if (stop_cnt_r == STOP_LAST) begin
                  done_nxt_s     = 1'b1;
                  stop_cnt_nxt_s = 1'b0;
               end else begin
                  stop_cnt_nxt_s = 1'b1;
               end
            end else begin
               stop_cnt_nxt_s = stop_cnt_r;
            end
         end
         default: begin
            tx_nxt_s = IDLE_LEVEL;
         end
      endcase
   end

   // Datapath and output registers; handshake flags follow the next state so tx_done and tx_ready rise together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_r    <= {DATA_BITS{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         stop_cnt_r <= 1'b0;
         tx_r       <= IDLE_LEVEL;
         done_r     <= 1'b0;
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         data_r     <= {DATA_BITS{1'b0}};
`endif
      end else begin
         shift_r    <= shift_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         stop_cnt_r <= stop_cnt_nxt_s;
         tx_r       <= tx_nxt_s;
         done_r     <= done_nxt_s;
         ready_r    <= (state_nxt_s == ST_IDLE);
         busy_r     <= (state_nxt_s != ST_IDLE);
`ifdef UART_TX_PARITY_EN
         data_r     <= data_nxt_s;
`endif
      end
   end

   assign tx       = tx_r;
   assign tx_done  = done_r;
   assign tx_ready = ready_r;
   assign tx_busy  = busy_r;

endmodule
